// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. It owns the HI/LO
// registers, serves MTHI/MTLO writes and MFHI/MFLO reads, and raises o_busy
// while an operation is in flight so hazard logic can hold ID/EX.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   defined   : MULT/MULTU leave RUN once the remaining multiplier bits are 0
//   undefined : every mul/div spends exactly NB_DATA cycles in RUN
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   i_start         valid muldiv/mt instruction in EX
//   i_func          MIPS funct field (MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO)
//   i_rs_reg        multiplicand / dividend / MT source
//   i_rt_reg        multiplier / divisor
//   o_busy          state != IDLE
//   o_done          one-cycle pulse, HI/LO just updated by mul/div
//   o_div_by_zero   one-cycle pulse with o_done when the divisor was zero
//   o_hi, o_lo      HI / LO registers
//   o_mf_data       HI when i_func is MFHI, otherwise LO
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_FUNC = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [NB_FUNC-1:0] i_func,
  input  logic [NB_DATA-1:0] i_rs_reg,
  input  logic [NB_DATA-1:0] i_rt_reg,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_by_zero,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo,
  output logic [NB_DATA-1:0] o_mf_data
);

  localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_FUNC-1:0] FN_MFHI  = NB_FUNC'(6'h10);
  localparam logic [NB_FUNC-1:0] FN_MTHI  = NB_FUNC'(6'h11);
  localparam logic [NB_FUNC-1:0] FN_MTLO  = NB_FUNC'(6'h13);
  localparam logic [NB_FUNC-1:0] FN_MULT  = NB_FUNC'(6'h18);
  localparam logic [NB_FUNC-1:0] FN_MULTU = NB_FUNC'(6'h19);
  localparam logic [NB_FUNC-1:0] FN_DIV   = NB_FUNC'(6'h1A);
  localparam logic [NB_FUNC-1:0] FN_DIVU  = NB_FUNC'(6'h1B);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [NB_CNT-1:0]      r_cnt;
  logic [2*NB_DATA-1:0]   r_acc;      // mul: product; div: {remainder, dividend/quotient}
  logic [2*NB_DATA-1:0]   r_a;        // mul: shifting multiplicand; div: divisor in low half
  logic [NB_DATA-1:0]     r_b;        // mul: shifting multiplier
  logic                   r_is_div;
  logic                   r_neg_res;  // negate product / quotient
  logic                   r_neg_rem;  // negate remainder (dividend sign)
  logic                   r_dbz;
  logic [NB_DATA-1:0]     r_hi;
  logic [NB_DATA-1:0]     r_lo;
  logic                   r_done;
  logic                   r_div_by_zero;

  logic                   w_is_md;
  logic                   w_is_div;
  logic                   w_is_signed;
  logic                   w_accept;
  logic                   w_dbz_start;
  logic                   w_rs_neg;
  logic                   w_rt_neg;
  logic [NB_DATA-1:0]     w_rs_abs;
  logic [NB_DATA-1:0]     w_rt_abs;
  logic [NB_DATA:0]       w_div_trial;
  logic                   w_div_qbit;
  logic [2*NB_DATA-1:0]   w_prod_fix;
  logic [NB_DATA-1:0]     w_quo_fix;
  logic [NB_DATA-1:0]     w_rem_fix;

  // Instruction decode and operand magnitude/sign extraction.
  always_comb begin
    w_is_md     = (i_func == FN_MULT) || (i_func == FN_MULTU) ||
                  (i_func == FN_DIV)  || (i_func == FN_DIVU);
    w_is_div    = (i_func == FN_DIV)  || (i_func == FN_DIVU);
    w_is_signed = (i_func == FN_MULT) || (i_func == FN_DIV);
    w_accept    = (r_state == ST_IDLE) && i_start && w_is_md;
    w_dbz_start = w_accept && w_is_div && (i_rt_reg == '0);
    w_rs_neg    = w_is_signed && i_rs_reg[NB_DATA-1];
    w_rt_neg    = w_is_signed && i_rt_reg[NB_DATA-1];
    w_rs_abs    = w_rs_neg ? (~i_rs_reg + NB_DATA'(1)) : i_rs_reg;
    w_rt_abs    = w_rt_neg ? (~i_rt_reg + NB_DATA'(1)) : i_rt_reg;
  end

  // Restoring-divide step: shift the next dividend bit into the remainder and
  // try subtracting the divisor; a clear sign bit means the subtraction fits.
  always_comb begin
    w_div_trial = r_acc[2*NB_DATA-1:NB_DATA-1] - {1'b0, r_a[NB_DATA-1:0]};
    w_div_qbit  = ~w_div_trial[NB_DATA];
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_prod_fix = r_neg_res ? (~r_acc + (2*NB_DATA)'(1)) : r_acc;
    w_quo_fix  = r_neg_res ? (~r_acc[NB_DATA-1:0] + NB_DATA'(1)) : r_acc[NB_DATA-1:0];
    w_rem_fix  = r_neg_rem ? (~r_acc[2*NB_DATA-1:NB_DATA] + NB_DATA'(1))
                           : r_acc[2*NB_DATA-1:NB_DATA];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dbz_start) begin
          w_state_next = ST_FIX;
        end else if (w_accept) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_state_next = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (!r_is_div && (r_b[NB_DATA-1:1] == '0)) begin
          // The bit consumed this cycle is the last set multiplier bit.
          w_state_next = ST_FIX;
`endif
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM / register outputs.
  always_comb begin
    o_busy        = (r_state != ST_IDLE);
    o_done        = r_done;
    o_div_by_zero = r_div_by_zero;
    o_hi          = r_hi;
    o_lo          = r_lo;
    o_mf_data     = (i_func == FN_MFHI) ? r_hi : r_lo;
  end

  // Datapath: operand latch, iteration, HI/LO write and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_is_div      <= 1'b0;
      r_neg_res     <= 1'b0;
      r_neg_rem     <= 1'b0;
      r_dbz         <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt    <= NB_CNT'(NB_DATA-1);
            r_is_div <= w_is_div;
            if (w_dbz_start) begin
              // Result preloaded so FIX writes HI=rs, LO=all ones unchanged.
              r_acc     <= {i_rs_reg, {NB_DATA{1'b1}}};
              r_a       <= '0;
              r_b       <= '0;
              r_neg_res <= 1'b0;
              r_neg_rem <= 1'b0;
              r_dbz     <= 1'b1;
            end else if (w_is_div) begin
              r_acc     <= {{NB_DATA{1'b0}}, w_rs_abs};
              r_a       <= {{NB_DATA{1'b0}}, w_rt_abs};
              r_b       <= '0;
              r_neg_res <= w_rs_neg ^ w_rt_neg;
              r_neg_rem <= w_rs_neg;
              r_dbz     <= 1'b0;
            end else begin
              r_acc     <= '0;
              r_a       <= {{NB_DATA{1'b0}}, w_rs_abs};
              r_b       <= w_rt_abs;
              r_neg_res <= w_rs_neg ^ w_rt_neg;
              r_neg_rem <= 1'b0;
              r_dbz     <= 1'b0;
            end
          end else if (i_start && (i_func == FN_MTHI)) begin
            r_hi <= i_rs_reg;
          end else if (i_start && (i_func == FN_MTLO)) begin
            r_lo <= i_rs_reg;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt - NB_CNT'(1);
          if (r_is_div) begin
            r_acc <= {(w_div_qbit ? w_div_trial[NB_DATA-1:0] : r_acc[2*NB_DATA-2:NB_DATA-1]),
                      r_acc[NB_DATA-2:0], w_div_qbit};
          end else begin
            if (r_b[0]) begin
              r_acc <= r_acc + r_a;
            end else begin
              r_acc <= r_acc;
            end
            r_a <= {r_a[2*NB_DATA-2:0], 1'b0};
            r_b <= {1'b0, r_b[NB_DATA-1:1]};
          end
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*NB_DATA-1:NB_DATA];
            r_lo <= w_prod_fix[NB_DATA-1:0];
          end
          r_done        <= 1'b1;
          r_div_by_zero <= r_dbz;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [5:0]  i_func;
  logic [31:0] i_rs_reg;
  logic [31:0] i_rt_reg;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic [31:0] o_mf_data;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {div_by_zero, HI, LO}
  logic [64:0] sb_q[$];

  ex_muldiv_unit #(.NB_DATA(32), .NB_FUNC(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_func        (i_func),
    .i_rs_reg      (i_rs_reg),
    .i_rt_reg      (i_rt_reg),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_mf_data     (o_mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {HI, LO} computed with 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (f)
      FN_MULTU: res = {32'd0, a} * {32'd0, b};
      FN_MULT:  res = sa * sb;
      FN_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      FN_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic int bit_len(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Expected number of cycles o_busy stays high after the accept edge.
  function automatic int exp_busy(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    if ((f == FN_DIV || f == FN_DIVU) && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (f == FN_MULT || f == FN_MULTU) begin
      mag = (f == FN_MULT && b[31]) ? (~b + 32'd1) : b;
      return ((bit_len(mag) > 1) ? bit_len(mag) : 1) + 1;
    end
`endif
    mag = a;
    return 33;
  endfunction

  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit inject);
    int busy_cnt;
    int exp_b;
    logic [64:0] exp_e;
    bit dbz;
    @(negedge clk);
    i_start  = 1'b1;
    i_func   = f;
    i_rs_reg = a;
    i_rt_reg = b;
    dbz = (f == FN_DIV || f == FN_DIVU) && (b == 32'd0);
    sb_q.push_back({dbz, model(f, a, b)});
    exp_b = exp_busy(f, a, b);
    @(posedge clk);
    #1;
    i_start  = 1'b0;
    i_func   = FN_MFLO;
    i_rs_reg = $urandom;   // must not disturb the operation in flight
    i_rt_reg = $urandom;
    busy_cnt = 0;
    @(negedge clk);
    while (o_busy && busy_cnt < 200) begin
      busy_cnt++;
      check_value("done_while_busy", {63'd0, o_done}, 64'd0);
      if (inject && busy_cnt == 5) begin
        i_start  = 1'b1;
        i_func   = FN_MULT;
        i_rs_reg = 32'h1357_9BDF;
        i_rt_reg = 32'h0000_0003;
      end else begin
        i_start  = 1'b0;
        i_func   = FN_MFLO;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    check_value("busy_cycles", 64'(busy_cnt), 64'(exp_b));
    check_value("done_pulse", {63'd0, o_done}, 64'd1);
    if (sb_q.size() == 0) begin
      check_value("sb_empty", 64'd1, 64'd0);
    end else begin
      exp_e = sb_q.pop_front();
      check_value("hi", {32'd0, o_hi}, {32'd0, exp_e[63:32]});
      check_value("lo", {32'd0, o_lo}, {32'd0, exp_e[31:0]});
      check_value("dbz", {63'd0, o_div_by_zero}, {63'd0, exp_e[64]});
    end
    @(negedge clk);
    check_value("done_low_after", {62'd0, o_done, o_div_by_zero}, 64'd0);
    check_value("idle_after", {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    int seen_done;
    logic [31:0] ra, rb;
    rst = 1'b1;
    i_start = 1'b0;
    i_func = FN_MFLO;
    i_rs_reg = 32'd0;
    i_rt_reg = 32'd0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", {63'd0, o_busy}, 64'd0);
    check_value("rst_done", {62'd0, o_done, o_div_by_zero}, 64'd0);
    check_value("rst_hilo", {o_hi, o_lo}, 64'd0);
    rst = 1'b0;

    do_op(FN_MULTU, 32'd7, 32'd6, 1'b0);
    do_op(FN_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(FN_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0);
    do_op(FN_DIV, 32'h1234, 32'd0, 1'b0);
    do_op(FN_DIVU, 32'hCAFE, 32'd0, 1'b0);
    do_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(FN_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(FN_MULT, 32'h1234_5678, 32'd0, 1'b0);
    do_op(FN_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0);
    // Second MULT presented while busy must be ignored.
    do_op(FN_MULTU, 32'h0001_0001, 32'hFFFF_0000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = (k == 3) ? 32'd1 : $urandom >> (k * 3);
      case (k % 4)
        0: do_op(FN_MULT, ra, rb, 1'b0);
        1: do_op(FN_MULTU, ra, rb, 1'b0);
        2: do_op(FN_DIV, ra, rb, 1'b0);
        default: do_op(FN_DIVU, ra, rb, 1'b0);
      endcase
    end

    // MTHI / MTLO and MFHI / MFLO.
    @(negedge clk);
    i_start = 1'b1; i_func = FN_MTHI; i_rs_reg = 32'hAA;
    @(posedge clk); #1;
    i_start = 1'b0; i_func = FN_MFHI;
    check_value("mthi_hi", {32'd0, o_hi}, 64'hAA);
    check_value("mthi_busy", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    check_value("mfhi", {32'd0, o_mf_data}, 64'hAA);
    i_start = 1'b1; i_func = FN_MTLO; i_rs_reg = 32'h5555_0001;
    @(posedge clk); #1;
    i_start = 1'b0; i_func = FN_MFLO;
    check_value("mtlo_lo", {32'd0, o_lo}, 64'h5555_0001);
    check_value("mtlo_hi_kept", {32'd0, o_hi}, 64'hAA);
    @(negedge clk);
    check_value("mflo", {32'd0, o_mf_data}, 64'h5555_0001);

    // Reset in the middle of RUN.
    @(negedge clk);
    i_start = 1'b1; i_func = FN_MULTU; i_rs_reg = 32'h1111_1111; i_rt_reg = 32'hF000_0001;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    check_value("busy_before_rst", {63'd0, o_busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_value("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    check_value("rst_mid_hilo", {o_hi, o_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done || o_busy) seen_done++;
    end
    check_value("no_done_after_rst", 64'(seen_done), 64'd0);

    check_value("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
